// File: rtl/tlb_ctrl.sv
// Request sequencer/arbiter in front of the set-associative TLB: round-robin lookup, miss walk, insert, flush.
// Optional build macro TLB_CTRL_STATS_EN adds saturating hit/miss/fault counters.
module tlb_ctrl #(
  parameter int SADDR    = 64,
  parameter int SPAGE    = 12,
  parameter int SPCID    = 12,
  parameter int TIMEOUT  = 8,
  parameter int INS_HOLD = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [SADDR-1:0] req0_va,
  input  logic [SPCID-1:0] req0_pcid,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [SADDR-1:0] req1_va,
  input  logic [SPCID-1:0] req1_pcid,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [SADDR-1:0] resp_pa,
  output logic             resp_fault,
  output logic [SADDR-1:0] tlb_va,
  output logic [SPCID-1:0] tlb_pcid,
  output logic [SADDR-1:0] tlb_pa,
  output logic             tlb_insert,
  output logic             tlb_shutdown,
  input  logic             tlb_hit,
  input  logic             tlb_miss,
  input  logic [SADDR-1:0] tlb_ta,
  output logic             walk_req,
  output logic [SADDR-1:0] walk_va,
  output logic [SPCID-1:0] walk_pcid,
  input  logic             walk_done,
  input  logic             walk_fault,
  input  logic [SADDR-1:0] walk_pa,
`ifdef TLB_CTRL_STATS_EN
  output logic [31:0]      stat_hits,
  output logic [31:0]      stat_misses,
  output logic [31:0]      stat_faults,
`endif
  input  logic             flush_req,
  output logic             flush_ack
);

  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int INS_W = $clog2(INS_HOLD + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WALK, S_INSERT, S_RESP, S_FLUSH
  } state_t;

  state_t             state_reg, state_next;
  logic               rr_reg, rr_next;
  logic               id_reg, id_next;
  logic [TO_W-1:0]    cnt_reg, cnt_next;
  logic [INS_W-1:0]   ins_cnt_reg, ins_cnt_next;
  logic               walk_first_reg, walk_first_next;
  logic               flush_phase_reg, flush_phase_next;
  logic [SADDR-1:0]   tlb_va_reg, tlb_va_next;
  logic [SPCID-1:0]   tlb_pcid_reg, tlb_pcid_next;
  logic [SADDR-1:0]   tlb_pa_reg, tlb_pa_next;
  logic [SADDR-1:0]   walk_va_reg, walk_va_next;
  logic [SPCID-1:0]   walk_pcid_reg, walk_pcid_next;
  logic [SADDR-1:0]   resp_pa_reg, resp_pa_next;
  logic               resp_fault_reg, resp_fault_next;

  logic [1:0] req_valid;
  logic [1:0] ready_vec;
  logic       grant_valid;
  logic       grant_id;
  logic       timeout_hit;

  assign req_valid   = {req1_valid, req0_valid};
  assign grant_valid = |req_valid;
  // With both requesters valid the rr pointer decides; otherwise the lone valid one wins.
  assign grant_id    = (&req_valid) ? rr_reg : req_valid[1];
  assign timeout_hit = (cnt_reg == TO_W'(TIMEOUT - 1));

  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    assign ready_vec[gi] = (state_reg == S_IDLE) && !rst && !flush_req &&
                           grant_valid && (grant_id == 1'(gi));
  end

  always_comb begin
    state_next       = state_reg;
    rr_next          = rr_reg;
    id_next          = id_reg;
    cnt_next         = cnt_reg;
    ins_cnt_next     = ins_cnt_reg;
    walk_first_next  = walk_first_reg;
    flush_phase_next = flush_phase_reg;
    tlb_va_next      = tlb_va_reg;
    tlb_pcid_next    = tlb_pcid_reg;
    tlb_pa_next      = tlb_pa_reg;
    walk_va_next     = walk_va_reg;
    walk_pcid_next   = walk_pcid_reg;
    resp_pa_next     = resp_pa_reg;
    resp_fault_next  = resp_fault_reg;
    case (state_reg)
      S_IDLE: begin
        if (flush_req) begin
          flush_phase_next = 1'b0;
          state_next       = S_FLUSH;
        end else if (grant_valid) begin
          id_next       = grant_id;
          rr_next       = ~grant_id;
          tlb_va_next   = grant_id ? req1_va : req0_va;
          tlb_pcid_next = grant_id ? req1_pcid : req0_pcid;
          cnt_next      = '0;
          state_next    = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        cnt_next = cnt_reg + TO_W'(1);
        if (tlb_hit) begin
          resp_pa_next    = tlb_ta;
          resp_fault_next = 1'b0;
          state_next      = S_RESP;
        end else if (tlb_miss || timeout_hit) begin
          walk_va_next    = tlb_va_reg;
          walk_pcid_next  = tlb_pcid_reg;
          walk_first_next = 1'b1;
          state_next      = S_WALK;
        end
      end
      S_WALK: begin
        walk_first_next = 1'b0;
        if (walk_done) begin
          if (walk_fault) begin
            resp_fault_next = 1'b1;
            resp_pa_next    = '0;
            state_next      = S_RESP;
          end else begin
            tlb_pa_next     = walk_pa;
            resp_pa_next    = {walk_pa[SADDR-1:SPAGE], tlb_va_reg[SPAGE-1:0]};
            resp_fault_next = 1'b0;
            ins_cnt_next    = '0;
            state_next      = S_INSERT;
          end
        end
      end
      S_INSERT: begin
        if (ins_cnt_reg == INS_W'(INS_HOLD)) begin
          state_next = S_RESP;
        end else begin
          ins_cnt_next = ins_cnt_reg + INS_W'(1);
        end
      end
      S_RESP: state_next = S_IDLE;
      S_FLUSH: begin
        if (!flush_phase_reg) begin
          flush_phase_next = 1'b1;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      rr_reg          <= 1'b0;
      id_reg          <= 1'b0;
      cnt_reg         <= '0;
      ins_cnt_reg     <= '0;
      walk_first_reg  <= 1'b0;
      flush_phase_reg <= 1'b0;
      tlb_va_reg      <= '0;
      tlb_pcid_reg    <= '0;
      tlb_pa_reg      <= '0;
      walk_va_reg     <= '0;
      walk_pcid_reg   <= '0;
      resp_pa_reg     <= '0;
      resp_fault_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      rr_reg          <= rr_next;
      id_reg          <= id_next;
      cnt_reg         <= cnt_next;
      ins_cnt_reg     <= ins_cnt_next;
      walk_first_reg  <= walk_first_next;
      flush_phase_reg <= flush_phase_next;
      tlb_va_reg      <= tlb_va_next;
      tlb_pcid_reg    <= tlb_pcid_next;
      tlb_pa_reg      <= tlb_pa_next;
      walk_va_reg     <= walk_va_next;
      walk_pcid_reg   <= walk_pcid_next;
      resp_pa_reg     <= resp_pa_next;
      resp_fault_reg  <= resp_fault_next;
    end
  end

  // Strobes decode straight from registered state, so reset forces them all low.
  assign req0_ready   = ready_vec[0];
  assign req1_ready   = ready_vec[1];
  assign resp_valid   = (state_reg == S_RESP);
  assign resp_id      = id_reg;
  assign resp_pa      = resp_pa_reg;
  assign resp_fault   = resp_fault_reg;
  assign tlb_va       = tlb_va_reg;
  assign tlb_pcid     = tlb_pcid_reg;
  assign tlb_pa       = tlb_pa_reg;
  assign tlb_insert   = (state_reg == S_INSERT) && (ins_cnt_reg == '0);
  assign tlb_shutdown = (state_reg == S_FLUSH) && !flush_phase_reg;
  assign flush_ack    = (state_reg == S_FLUSH) && flush_phase_reg;
  assign walk_req     = (state_reg == S_WALK) && walk_first_reg;
  assign walk_va      = walk_va_reg;
  assign walk_pcid    = walk_pcid_reg;

`ifdef TLB_CTRL_STATS_EN
  logic [2:0]  stat_evt;
  logic [31:0] stat_cnt_reg [3];

  assign stat_evt[0] = (state_reg == S_LOOKUP) && (state_next == S_RESP);
  assign stat_evt[1] = (state_reg == S_LOOKUP) && (state_next == S_WALK);
  assign stat_evt[2] = (state_reg == S_WALK) && walk_done && walk_fault;

  for (genvar gi = 0; gi < 3; gi++) begin : g_stat
    always_ff @(posedge clk) begin
      if (rst) begin
        stat_cnt_reg[gi] <= '0;
      end else if (stat_evt[gi] && (stat_cnt_reg[gi] != '1)) begin
        stat_cnt_reg[gi] <= stat_cnt_reg[gi] + 32'd1;
      end
    end
  end

  assign stat_hits   = stat_cnt_reg[0];
  assign stat_misses = stat_cnt_reg[1];
  assign stat_faults = stat_cnt_reg[2];
`endif

endmodule

// File: tb/tb_tlb_ctrl.sv
// Directed bench for tlb_ctrl: hit, miss/walk/insert, round-robin, timeout fault, deferred flush, reset mid-insert.
module tb_tlb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [63:0] req0_va, req1_va;
  logic [11:0] req0_pcid, req1_pcid;
  logic        resp_valid, resp_id, resp_fault;
  logic [63:0] resp_pa;
  logic [63:0] tlb_va, tlb_pa, tlb_ta;
  logic [11:0] tlb_pcid;
  logic        tlb_insert, tlb_shutdown, tlb_hit, tlb_miss;
  logic        walk_req, walk_done, walk_fault;
  logic [63:0] walk_va, walk_pa;
  logic [11:0] walk_pcid;
  logic        flush_req, flush_ack;
`ifdef TLB_CTRL_STATS_EN
  logic [31:0] stat_hits, stat_misses, stat_faults;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tlb_ctrl dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_va(req0_va), .req0_pcid(req0_pcid),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_va(req1_va), .req1_pcid(req1_pcid),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_pa(resp_pa), .resp_fault(resp_fault),
    .tlb_va(tlb_va), .tlb_pcid(tlb_pcid), .tlb_pa(tlb_pa), .tlb_insert(tlb_insert),
    .tlb_shutdown(tlb_shutdown), .tlb_hit(tlb_hit), .tlb_miss(tlb_miss), .tlb_ta(tlb_ta),
    .walk_req(walk_req), .walk_va(walk_va), .walk_pcid(walk_pcid), .walk_done(walk_done),
    .walk_fault(walk_fault), .walk_pa(walk_pa),
`ifdef TLB_CTRL_STATS_EN
    .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_faults(stat_faults),
`endif
    .flush_req(flush_req), .flush_ack(flush_ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  initial begin
    logic [63:0] va0, va1, exp_va;
    logic        exp_id;

    rst = 1'b1; req0_valid = 0; req1_valid = 0; req0_va = '0; req1_va = '0;
    req0_pcid = '0; req1_pcid = '0; tlb_hit = 0; tlb_miss = 0; tlb_ta = '0;
    walk_done = 0; walk_fault = 0; walk_pa = '0; flush_req = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_tlb_va", tlb_va, 0);
    check("rst_walk_req", walk_req, 0);
    check("rst_insert", tlb_insert, 0);
    check("rst_shutdown", tlb_shutdown, 0);
    check("rst_flush_ack", flush_ack, 0);
    check("rst_ready0", req0_ready, 0);

    // hit on req0
    req0_valid = 1; req0_va = 64'h0000_1234_5678_9ABC; req0_pcid = 12'd5;
    #1;
    check("t1_ready0", req0_ready, 1);
    check("t1_ready1", req1_ready, 0);
    tick();
    req0_valid = 0;
    check("t1_tlb_va", tlb_va, 64'h0000_1234_5678_9ABC);
    check("t1_tlb_pcid", tlb_pcid, 5);
    tlb_hit = 1; tlb_ta = 64'h0000_0000_0420_9ABC;
    tick();
    tlb_hit = 0;
    check("t1_resp_valid", resp_valid, 1);
    check("t1_resp_id", resp_id, 0);
    check("t1_resp_pa", resp_pa, 64'h0000_0000_0420_9ABC);
    check("t1_walk_req", walk_req, 0);
    tick();
    check("t1_resp_once", resp_valid, 0);
    $display("txn t1 hit req0 done");

    // miss on req1, walk, insert
    req1_valid = 1; req1_va = 64'h7000_3123; req1_pcid = 12'h00A;
    #1;
    check("t2_ready1", req1_ready, 1);
    tick();
    req1_valid = 0; tlb_miss = 1;
    tick();
    tlb_miss = 0;
    check("t2_walk_req", walk_req, 1);
    check("t2_walk_va", walk_va, 64'h7000_3123);
    check("t2_walk_pcid", walk_pcid, 12'h00A);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t2_walk_req_once", walk_req, 0);
    end
    walk_done = 1; walk_pa = 64'h8000_0000;
    tick();
    walk_done = 0;
    check("t2_insert", tlb_insert, 1);
    check("t2_tlb_pa", tlb_pa, 64'h8000_0000);
    check("t2_tlb_va", tlb_va, 64'h7000_3123);
    for (int c = 0; c < 2; c++) begin
      tick();
      check("t2_insert_once", tlb_insert, 0);
      check("t2_va_hold", tlb_va, 64'h7000_3123);
      check("t2_pa_hold", tlb_pa, 64'h8000_0000);
      check("t2_no_resp_yet", resp_valid, 0);
    end
    tick();
    check("t2_resp_valid", resp_valid, 1);
    check("t2_resp_pa", resp_pa, 64'h8000_0123);
    check("t2_resp_id", resp_id, 1);
    tick();
    check("t2_resp_once", resp_valid, 0);
    $display("txn t2 miss/walk/insert req1 done");

    // both requesters valid: 0,1,0,1
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 4; i++) begin
      va0 = 64'h0000_A000 + 64'(i) * 64'h1000;
      va1 = 64'h0000_B000 + 64'(i) * 64'h1000;
      req0_va = va0; req1_va = va1;
      exp_id = 1'(i % 2);
      exp_va = exp_id ? va1 : va0;
      #1;
      check("t3_ready0", req0_ready, !exp_id);
      check("t3_ready1", req1_ready, exp_id);
      tick();
      check("t3_tlb_va", tlb_va, exp_va);
      tlb_hit = 1; tlb_ta = exp_va ^ 64'hF000_0000;
      tick();
      tlb_hit = 0;
      check("t3_resp_valid", resp_valid, 1);
      check("t3_resp_id", resp_id, exp_id);
      check("t3_resp_pa", resp_pa, exp_va ^ 64'hF000_0000);
      check("t3_no_ready_in_resp", {req1_ready, req0_ready}, 0);
      $display("txn t3 grant %0d id=%0d pa=%0h", i, resp_id, resp_pa);
      tick();
    end
    req0_valid = 0; req1_valid = 0;

    // silent TLB -> timeout walk, faulting
    req0_valid = 1; req0_va = 64'h5555;
    #1;
    check("t4_ready0", req0_ready, 1);
    tick();
    req0_valid = 0;
    for (int c = 1; c <= 8; c++) begin
      check("t4_no_walk_before_timeout", walk_req, 0);
      tick();
    end
    check("t4_walk_req_cycle9", walk_req, 1);
    walk_done = 1; walk_fault = 1; walk_pa = 64'hDEAD_0000;
    #1;
    check("t4_no_insert_walk", tlb_insert, 0);
    tick();
    walk_done = 0; walk_fault = 0;
    check("t4_resp_valid", resp_valid, 1);
    check("t4_resp_fault", resp_fault, 1);
    check("t4_resp_pa", resp_pa, 0);
    check("t4_no_insert", tlb_insert, 0);
    tick();
    check("t4_resp_once", resp_valid, 0);
    $display("txn t4 timeout fault done");

    // flush raised during walk is deferred
    req1_valid = 1; req1_va = 64'h1234_5678;
    tick();
    req1_valid = 0; tlb_miss = 1;
    tick();
    tlb_miss = 0; flush_req = 1;
    check("t5_walk_req", walk_req, 1);
    tick();
    check("t5_no_shutdown_in_walk", tlb_shutdown, 0);
    walk_done = 1; walk_pa = 64'h9999_9000;
    tick();
    walk_done = 0;
    check("t5_insert", tlb_insert, 1);
    req0_valid = 1; req0_va = 64'h4444_4000;
    tick(); tick();
    tick();
    check("t5_resp_valid", resp_valid, 1);
    check("t5_resp_pa", resp_pa, 64'h9999_9678);
    tick();
    check("t5_idle_ready_blocked", req0_ready, 0);
    check("t5_idle_no_shutdown", tlb_shutdown, 0);
    tick();
    check("t5_shutdown", tlb_shutdown, 1);
    check("t5_ack_early", flush_ack, 0);
    flush_req = 0;
    tick();
    check("t5_shutdown_once", tlb_shutdown, 0);
    check("t5_flush_ack", flush_ack, 1);
    tick();
    check("t5_ack_once", flush_ack, 0);
    check("t5_ready_after_flush", req0_ready, 1);
    $display("txn t5 deferred flush done");

    // reset during insert
    tick();
    req0_valid = 0; tlb_miss = 1;
    tick();
    tlb_miss = 0; walk_done = 1; walk_pa = 64'h5000;
    tick();
    walk_done = 0;
    check("t6_insert", tlb_insert, 1);
`ifdef TLB_CTRL_STATS_EN
    check("t6_stat_hits_pre", stat_hits, 5);
    check("t6_stat_misses_pre", stat_misses, 4);
    check("t6_stat_faults_pre", stat_faults, 1);
`endif
    rst = 1;
    tick();
    rst = 0;
    #1;
    check("t6_resp_valid", resp_valid, 0);
    check("t6_insert_cleared", tlb_insert, 0);
    check("t6_tlb_va", tlb_va, 0);
    check("t6_tlb_pa", tlb_pa, 0);
    check("t6_walk_va", walk_va, 0);
    check("t6_resp_pa", resp_pa, 0);
`ifdef TLB_CTRL_STATS_EN
    check("t6_stat_hits", stat_hits, 0);
    check("t6_stat_misses", stat_misses, 0);
    check("t6_stat_faults", stat_faults, 0);
`endif
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t6_no_resp", resp_valid, 0);
    end
    $display("txn t6 reset during insert done");

    // after reset a plain hit works again
    req1_valid = 1; req1_va = 64'h0000_0000_0000_7ABC;
    #1;
    check("t7_ready1", req1_ready, 1);
    tick();
    req1_valid = 0; tlb_hit = 1; tlb_ta = 64'h0000_0000_0003_3ABC;
    tick();
    tlb_hit = 0;
    check("t7_resp_pa", resp_pa, 64'h0000_0000_0003_3ABC);
    check("t7_resp_id", resp_id, 1);
    $display("txn t7 post-reset hit done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
